char_input_ctrl: RTL and testbench
==================================

Name: char_input_ctrl

Overview:
- Conditions raw player key levels into clean movement and shoot commands for the character.
- Sits directly upstream of the character movement stage: drives its leftPress and rightPress inputs.
- Drives the rope/shot spawner with a single-cycle shootPulse.
- Performs synchronisation, debounce, left/right arbitration and a frame-counted shoot cooldown.

Parameters:
- DEBOUNCE_CYCLES, 500000, clk cycles a synchronised key level must hold before being accepted (10 ms at 50 MHz); minimum 2.
- COOLDOWN_FRAMES, 15, startOfFrame pulses after a shot during which no new shot is issued; minimum 1, at most 255.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- keyLeftRaw  in  1  left key level from keyboard decoder, asynchronous, active-high
- keyRightRaw  in  1  right key level, asynchronous, active-high
- keyShootRaw  in  1  shoot key level, asynchronous, active-high
- shotActive  in  1  high while a rope is on screen; blocks new shots
- leftPress  out  1  registered move-left level
- rightPress  out  1  registered move-right level
- shootPulse  out  1  registered one-cycle fire command

Behaviour:
- Reset (asynchronous, resetN low): all outputs 0, synchronisers 0, stable levels 0, debounce counters 0, priority = NONE, shoot FSM = IDLE, cooldown = 0. Reset mid-operation aborts any pending debounce or cooldown.
- Synchroniser: two flops per key.
- Debounce, per key:
  - Counter clears whenever synced == stable.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, stable <= synced and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Latency: raw edge held steady -> output change after exactly DEBOUNCE_CYCLES+3 rising clk edges.
- Arbitration, registered:
  - Only left stable: leftPress=1, rightPress=0. Only right: the reverse. Neither: both 0, priority = NONE.
  - Both stable: the key whose stable level rose most recently wins (last-pressed priority register). Releasing the winner hands control to the still-held key on the next cycle.
  - Both keys stabilise in the same cycle: LEFT wins.
  - leftPress and rightPress are never 1 together.
- Shoot FSM, states IDLE, COOLDOWN, WAIT_RELEASE:
  - IDLE: on the rising edge of stable shoot with shotActive=0 and cooldown=0 -> shootPulse=1 for exactly one cycle, cooldown <= COOLDOWN_FRAMES, go to COOLDOWN. A rising edge while shotActive=1 is dropped, never queued.
  - COOLDOWN: cooldown decrements on each startOfFrame. At 0 -> WAIT_RELEASE if shoot is still held, else IDLE.
  - WAIT_RELEASE: stable shoot low -> IDLE.
  - startOfFrame arriving in the same cycle as the shot: the load wins, no decrement.
- Cooldown counter is 8 bits and saturates at 0; it never wraps.

Optional Feature:
- Macro: CHAR_AUTOFIRE_EN.
- Defined: WAIT_RELEASE is bypassed. When the cooldown expires with shoot held and shotActive=0, a new shootPulse is issued on the next cycle and cooldown reloads. If shotActive=1 the FSM waits in IDLE and fires when shotActive drops, provided shoot is still held.
- Undefined: every shot requires release and re-press.

Decomposition:
- Package char_pkg holds:
  - shoot_state_t enum {IDLE, COOLDOWN, WAIT_RELEASE}
  - dir_t enum {DIR_NONE, DIR_LEFT, DIR_RIGHT} for the priority register
  - CNT_W localparam for debounce counter width, derived with $clog2(DEBOUNCE_CYCLES)
- Sub-module key_debounce (synchroniser + counter + stable level + rise strobe), instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=3):
- keyLeftRaw 0->1 held -> leftPress rises exactly 7 clk edges later. rightPress stays 0. A 3-cycle left glitch -> leftPress never rises.
- Left held and stable, then right pressed -> after 7 edges rightPress=1, leftPress=0. Release right -> leftPress=1 after 7 edges.
- Both raw keys rise in the same cycle -> leftPress=1, rightPress=0.
- Shoot pressed with shotActive=0 -> one shootPulse 7 edges later. Held for 10 frames -> no further pulse. Release, then re-press after 3 startOfFrame pulses -> second pulse.
- Shoot re-pressed after 1 frame (cooldown=2) -> no pulse. Press while shotActive=1 -> no pulse, and none later when shotActive drops.
- resetN asserted during COOLDOWN -> outputs 0 immediately. After release, a new press fires without waiting. With CHAR_AUTOFIRE_EN: holding shoot -> a pulse every 3 frames.

Source files
------------

// File: rtl/char_pkg.sv
// Shared types and default sizing for the character input conditioning block.
package char_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned COOLDOWN_FRAMES_DEF = 15;
  localparam int unsigned CNT_W               = $clog2(DEBOUNCE_CYCLES_DEF);
  localparam int unsigned CD_W                = 8;

  typedef enum logic [1:0] {
    IDLE,
    COOLDOWN,
    WAIT_RELEASE
  } shoot_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus hold-time debounce for one key; emits the accepted
// level and a one-cycle strobe when the accepted level rises.
module key_debounce
  import char_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic key_raw,
  output logic stable,
  output logic rise
);

  localparam int unsigned REQ_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned W     = (REQ_W > CNT_W) ? REQ_W : CNT_W;
  localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         sync1_q, sync2_q;
  logic         stable_q, stable_d;
  logic         rise_q, rise_d;
  logic [W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced level disagrees with the accepted one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/char_input_ctrl.sv
// Turns raw player keys into exclusive left/right move levels and a frame-rate-limited
// shoot pulse. Define CHAR_AUTOFIRE_EN to let a held shoot key refire after each cooldown.
module char_input_ctrl
  import char_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic keyLeftRaw,
  input  logic keyRightRaw,
  input  logic keyShootRaw,
  input  logic shotActive,
  output logic leftPress,
  output logic rightPress,
  output logic shootPulse
);

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  logic left_stable, left_rise;
  logic right_stable, right_rise;
  logic shoot_stable, shoot_rise;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk    (clk),
    .resetN (resetN),
    .key_raw(keyLeftRaw),
    .stable (left_stable),
    .rise   (left_rise)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk    (clk),
    .resetN (resetN),
    .key_raw(keyRightRaw),
    .stable (right_stable),
    .rise   (right_rise)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_shoot (
    .clk    (clk),
    .resetN (resetN),
    .key_raw(keyShootRaw),
    .stable (shoot_stable),
    .rise   (shoot_rise)
  );

  dir_t            dir_q, dir_d;
  logic            left_press_q, left_press_d;
  logic            right_press_q, right_press_d;
  shoot_state_t    state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            shoot_pulse_q, shoot_pulse_d;
  logic            fire_req;

  // Last-pressed wins when both keys are held; a same-cycle tie goes to left.
  always_comb begin
    dir_d = dir_q;
    case ({left_stable, right_stable})
      2'b00: dir_d = DIR_NONE;
      2'b10: dir_d = DIR_LEFT;
      2'b01: dir_d = DIR_RIGHT;
      default: begin
        if (left_rise) begin
          dir_d = DIR_LEFT;
        end else if (right_rise) begin
          dir_d = DIR_RIGHT;
        end else if (dir_q == DIR_NONE) begin
          dir_d = DIR_LEFT;
        end
      end
    endcase
    left_press_d  = (dir_d == DIR_LEFT);
    right_press_d = (dir_d == DIR_RIGHT);
  end

  // Shoot FSM: fire, then hold off for a number of frames before accepting another shot.
  always_comb begin
    state_d       = state_q;
    cd_d          = cd_q;
    shoot_pulse_d = 1'b0;
`ifdef CHAR_AUTOFIRE_EN
    fire_req      = shoot_stable | shoot_rise;
`else
    fire_req      = shoot_rise;
`endif
    case (state_q)
      IDLE: begin
        if (fire_req && !shotActive && (cd_q == '0)) begin
          shoot_pulse_d = 1'b1;
          cd_d          = CD_LOAD;
          state_d       = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (startOfFrame && (cd_q != '0)) begin
          cd_d = cd_q - CD_W'(1);
        end
        if (cd_d == '0) begin
`ifdef CHAR_AUTOFIRE_EN
          state_d = IDLE;
`else
          state_d = shoot_stable ? WAIT_RELEASE : IDLE;
`endif
        end
      end
      WAIT_RELEASE: begin
        if (!shoot_stable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dir_q         <= DIR_NONE;
      left_press_q  <= 1'b0;
      right_press_q <= 1'b0;
      state_q       <= IDLE;
      cd_q          <= '0;
      shoot_pulse_q <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      left_press_q  <= left_press_d;
      right_press_q <= right_press_d;
      state_q       <= state_d;
      cd_q          <= cd_d;
      shoot_pulse_q <= shoot_pulse_d;
    end
  end

  assign leftPress  = left_press_q;
  assign rightPress = right_press_q;
  assign shootPulse = shoot_pulse_q;

endmodule

// File: tb/tb_char_input_ctrl.sv
// Self-checking bench for char_input_ctrl: directed scenarios plus a random run
// against a timestamp-based reference model of debounce, arbitration and shoot rate limiting.
module tb_char_input_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned CDF = 3;
  localparam int          LAT = DEB + 3;
`ifdef CHAR_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic keyLeftRaw = 1'b0;
  logic keyRightRaw = 1'b0;
  logic keyShootRaw = 1'b0;
  logic shotActive = 1'b0;
  logic leftPress, rightPress, shootPulse;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  char_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .COOLDOWN_FRAMES(CDF)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .keyLeftRaw  (keyLeftRaw),
    .keyRightRaw (keyRightRaw),
    .keyShootRaw (keyShootRaw),
    .shotActive  (shotActive),
    .leftPress   (leftPress),
    .rightPress  (rightPress),
    .shootPulse  (shootPulse)
  );

  // Reference model: keys are delayed two samples, accepted after DEB consecutive
  // disagreeing samples; direction chosen by most recent acceptance time.
  logic [2:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_raw;
  int         m_run [3];
  longint     m_rise_t [3];
  longint     edge_no = 0;
  bit         m_shoot_rose = 1'b0;
  int         m_frames_left = 0;
  bit         m_need_release = 1'b0;
  logic       e_left = 1'b0, e_right = 1'b0, e_shoot = 1'b0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      for (int k = 0; k < 3; k++) begin m_run[k] = 0; m_rise_t[k] = -1; end
      edge_no = 0; m_shoot_rose = 1'b0; m_frames_left = 0; m_need_release = 1'b0;
      e_left = 1'b0; e_right = 1'b0; e_shoot = 1'b0;
    end else begin
      edge_no++;
      if (m_stable[0] && m_stable[1]) begin
        e_left  = (m_rise_t[0] >= m_rise_t[1]);
        e_right = !e_left;
      end else begin
        e_left  = m_stable[0];
        e_right = m_stable[1];
      end
      e_shoot = 1'b0;
      if (m_frames_left > 0) begin
        if (startOfFrame) m_frames_left--;
        if (m_frames_left == 0 && m_stable[2] && !AUTOFIRE) m_need_release = 1'b1;
      end else if (m_need_release) begin
        if (!m_stable[2]) m_need_release = 1'b0;
      end else if ((AUTOFIRE ? m_stable[2] : m_shoot_rose) && !shotActive) begin
        e_shoot = 1'b1;
        m_frames_left = int'(CDF);
      end
      m_shoot_rose = 1'b0;
      m_raw = {keyShootRaw, keyRightRaw, keyLeftRaw};
      for (int k = 0; k < 3; k++) begin
        if (m_s2[k] != m_stable[k]) begin
          m_run[k]++;
          if (m_run[k] == int'(DEB)) begin
            m_stable[k] = m_s2[k];
            m_run[k] = 0;
            if (m_stable[k]) begin
              m_rise_t[k] = edge_no;
              if (k == 2) m_shoot_rose = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = m_raw;
    end
  end

  always @(posedge clk) begin
    #1;
    if (shootPulse === 1'b1) pulse_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); startOfFrame = 1'b1;
      @(negedge clk); startOfFrame = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Edges until the selected output goes high (0 = left, 1 = right, 2 = shoot); 0 on timeout.
  task automatic wait_for(input int which, output int lat);
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if ((which == 0 && leftPress === 1'b1) || (which == 1 && rightPress === 1'b1) ||
          (which == 2 && shootPulse === 1'b1)) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic test_reset;
    idle(3);
    n_cmp++; if (leftPress !== 1'b0) begin n_err++; $display("FAIL reset_left got=%b exp=0", leftPress); end
    n_cmp++; if (rightPress !== 1'b0) begin n_err++; $display("FAIL reset_right got=%b exp=0", rightPress); end
    n_cmp++; if (shootPulse !== 1'b0) begin n_err++; $display("FAIL reset_shoot got=%b exp=0", shootPulse); end
    resetN = 1'b1;
    idle(10);
    n_cmp++; if ({leftPress, rightPress, shootPulse} !== 3'b000) begin
      n_err++; $display("FAIL post_reset_idle got=%b exp=000", {leftPress, rightPress, shootPulse});
    end
  endtask

  task automatic test_left_latency;
    int lat;
    bit saw_r = 1'b0;
    keyLeftRaw = 1'b1;
    lat = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (rightPress === 1'b1) saw_r = 1'b1;
      if (leftPress === 1'b1) begin lat = j; break; end
    end
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL left_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (saw_r) begin n_err++; $display("FAIL left_only_right got=1 exp=0"); end
    keyLeftRaw = 1'b0;
    wait_for(0, lat);
    idle(12);
    n_cmp++; if (leftPress !== 1'b0) begin n_err++; $display("FAIL left_release got=%b exp=0", leftPress); end
  endtask

  task automatic test_glitch;
    bit saw = 1'b0;
    keyLeftRaw = 1'b1;
    idle(DEB - 1);
    keyLeftRaw = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (leftPress === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (saw) begin n_err++; $display("FAIL glitch_short got=1 exp=0"); end
    saw = 1'b0;
    keyLeftRaw = 1'b1;
    idle(DEB);
    keyLeftRaw = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (leftPress === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (!saw) begin n_err++; $display("FAIL glitch_boundary got=0 exp=1"); end
    idle(12);
  endtask

  task automatic test_priority;
    int lat;
    keyLeftRaw = 1'b1;
    idle(10);
    n_cmp++; if (leftPress !== 1'b1) begin n_err++; $display("FAIL prio_left_held got=%b exp=1", leftPress); end
    keyRightRaw = 1'b1;
    wait_for(1, lat);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL prio_right_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (leftPress !== 1'b0) begin n_err++; $display("FAIL prio_right_wins_left got=%b exp=0", leftPress); end
    keyRightRaw = 1'b0;
    wait_for(0, lat);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL prio_handback_latency got=%0d exp=%0d", lat, LAT); end
    n_cmp++; if (rightPress !== 1'b0) begin n_err++; $display("FAIL prio_handback_right got=%b exp=0", rightPress); end
    keyLeftRaw = 1'b0;
    idle(12);
  endtask

  task automatic test_simultaneous;
    keyLeftRaw = 1'b1; keyRightRaw = 1'b1;
    idle(LAT - 1);
    n_cmp++; if (leftPress !== 1'b0) begin n_err++; $display("FAIL simul_early got=%b exp=0", leftPress); end
    idle(1);
    n_cmp++; if ({leftPress, rightPress} !== 2'b10) begin
      n_err++; $display("FAIL simul_left_wins got=%b exp=10", {leftPress, rightPress});
    end
    idle(5);
    n_cmp++; if ({leftPress, rightPress} !== 2'b10) begin
      n_err++; $display("FAIL simul_hold got=%b exp=10", {leftPress, rightPress});
    end
    keyLeftRaw = 1'b0; keyRightRaw = 1'b0;
    idle(12);
  endtask

  task automatic test_shoot;
    int lat, p0;
    p0 = pulse_cnt;
    keyShootRaw = 1'b1;
    wait_for(2, lat);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL shoot_latency got=%0d exp=%0d", lat, LAT); end
    @(negedge clk);
    n_cmp++; if (shootPulse !== 1'b0) begin n_err++; $display("FAIL shoot_one_cycle got=%b exp=0", shootPulse); end
    frames(10, 4);
    n_cmp++; if (pulse_cnt - p0 != (AUTOFIRE ? 4 : 1)) begin
      n_err++; $display("FAIL shoot_held_pulses got=%0d exp=%0d", pulse_cnt - p0, AUTOFIRE ? 4 : 1);
    end
    keyShootRaw = 1'b0;
    idle(12);
    frames(3, 4);
    keyShootRaw = 1'b1;
    wait_for(2, lat);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL shoot_repress got=%0d exp=%0d", lat, LAT); end
    keyShootRaw = 1'b0;
    frames(4, 4);
    idle(12);
  endtask

  task automatic test_cooldown_block;
    int lat, p0;
    p0 = pulse_cnt;
    keyShootRaw = 1'b1;
    wait_for(2, lat);
    keyShootRaw = 1'b0;
    idle(10);
    frames(1, 2);
    keyShootRaw = 1'b1;
    idle(10);
    n_cmp++; if (pulse_cnt - p0 != 1) begin
      n_err++; $display("FAIL cooldown_drop got=%0d exp=1", pulse_cnt - p0);
    end
    frames(4, 4);
    n_cmp++; if (pulse_cnt - p0 != (AUTOFIRE ? 2 : 1)) begin
      n_err++; $display("FAIL cooldown_expire_held got=%0d exp=%0d", pulse_cnt - p0, AUTOFIRE ? 2 : 1);
    end
    keyShootRaw = 1'b0;
    frames(4, 4);
    idle(12);
  endtask

  task automatic test_shot_active;
    int p0;
    p0 = pulse_cnt;
    shotActive = 1'b1;
    keyShootRaw = 1'b1;
    idle(15);
    n_cmp++; if (pulse_cnt - p0 != 0) begin n_err++; $display("FAIL shot_active_block got=%0d exp=0", pulse_cnt - p0); end
    shotActive = 1'b0;
    idle(10);
    n_cmp++; if (pulse_cnt - p0 != (AUTOFIRE ? 1 : 0)) begin
      n_err++; $display("FAIL shot_active_drop got=%0d exp=%0d", pulse_cnt - p0, AUTOFIRE ? 1 : 0);
    end
    keyShootRaw = 1'b0;
    frames(4, 4);
    idle(12);
  endtask

  task automatic test_reset_mid;
    int lat;
    keyLeftRaw = 1'b1; keyShootRaw = 1'b1;
    wait_for(2, lat);
    n_cmp++; if (leftPress !== 1'b1) begin n_err++; $display("FAIL rmid_pre_left got=%b exp=1", leftPress); end
    #2 resetN = 1'b0;
    #1;
    n_cmp++; if ({leftPress, rightPress, shootPulse} !== 3'b000) begin
      n_err++; $display("FAIL rmid_outputs got=%b exp=000", {leftPress, rightPress, shootPulse});
    end
    keyLeftRaw = 1'b0; keyShootRaw = 1'b0;
    @(negedge clk); resetN = 1'b1;
    @(negedge clk);
    keyShootRaw = 1'b1;
    wait_for(2, lat);
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL rmid_fire_after got=%0d exp=%0d", lat, LAT); end
    keyShootRaw = 1'b0;
    frames(4, 4);
    idle(12);
  endtask

`ifdef CHAR_AUTOFIRE_EN
  task automatic test_autofire;
    int lat, p0;
    p0 = pulse_cnt;
    keyShootRaw = 1'b1;
    wait_for(2, lat);
    frames(9, 4);
    idle(4);
    n_cmp++; if (pulse_cnt - p0 != 4) begin n_err++; $display("FAIL autofire_count got=%0d exp=4", pulse_cnt - p0); end
    keyShootRaw = 1'b0;
    frames(4, 4);
    idle(12);
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n_cmp++; if (leftPress !== e_left) begin n_err++; $display("FAIL rand_left cyc=%0d got=%b exp=%b", i, leftPress, e_left); end
      n_cmp++; if (rightPress !== e_right) begin n_err++; $display("FAIL rand_right cyc=%0d got=%b exp=%b", i, rightPress, e_right); end
      n_cmp++; if (shootPulse !== e_shoot) begin n_err++; $display("FAIL rand_shoot cyc=%0d got=%b exp=%b", i, shootPulse, e_shoot); end
      n_cmp++; if (leftPress === 1'b1 && rightPress === 1'b1) begin n_err++; $display("FAIL rand_exclusive cyc=%0d got=11 exp=not11", i); end
      if ($urandom_range(5) == 0) keyLeftRaw = ~keyLeftRaw;
      if ($urandom_range(5) == 0) keyRightRaw = ~keyRightRaw;
      if ($urandom_range(5) == 0) keyShootRaw = ~keyShootRaw;
      if ($urandom_range(39) == 0) shotActive = ~shotActive;
      startOfFrame = ($urandom_range(7) == 0);
    end
    startOfFrame = 1'b0;
  endtask

  initial begin
    test_reset;
    test_left_latency;
    test_glitch;
    test_priority;
    test_simultaneous;
    test_shoot;
    test_cooldown_block;
    test_shot_active;
    test_reset_mid;
`ifdef CHAR_AUTOFIRE_EN
    test_autofire;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
